// File: rtl/flash_miso_merge_if.sv
// Host-side SPI pins, flash MISO lines and the compare/statistics outputs
// of flash_miso_merge, bundled for the design and its bench.
interface flash_miso_merge_if #(
  parameter int CNT_W = 16
);
  logic             h_clk;
  logic             h_cs_n;
  logic             mf_miso;
  logic             sf_miso;
  logic [1:0]       active_mode;
  logic             clr_stats;
  logic             h_miso;
  logic             byte_valid;
  logic [7:0]       byte_main;
  logic [7:0]       byte_sec;
  logic             mismatch;
  logic [CNT_W-1:0] mismatch_count;
  logic             first_mis_valid;
  logic [CNT_W-1:0] first_mis_byte;

  modport slave (
    input  h_clk, h_cs_n, mf_miso, sf_miso, active_mode, clr_stats,
    output h_miso, byte_valid, byte_main, byte_sec, mismatch,
           mismatch_count, first_mis_valid, first_mis_byte
  );

  modport master (
    output h_clk, h_cs_n, mf_miso, sf_miso, active_mode, clr_stats,
    input  h_miso, byte_valid, byte_main, byte_sec, mismatch,
           mismatch_count, first_mis_valid, first_mis_byte
  );
endinterface

// File: rtl/flash_miso_merge.sv
// Routes flash MISO back to the host and, in SHARE mode, compares the bytes
// returned by the main and secondary flash, keeping sticky mismatch statistics.
module flash_miso_merge #(
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_BYTES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  flash_miso_merge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CLOSE} state_t;

  localparam logic [31:0]      SKIP_L  = 32'(SKIP_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_hclk_sy, r_cs_sy, r_mf_sy, r_sf_sy, r_flush;
  logic                   r_hclk_d, r_cs_d, r_armed;
  logic                   w_hclk_s, w_cs_s, w_mf_s, w_sf_s;
  logic                   w_re, w_cs_fall, w_cs_rise;

  state_t                 r_state, w_state_nxt;
  logic                   r_fall_pend;
  logic                   w_start, w_bit, w_byte_done, w_cmp, w_mis;
  logic [1:0]             r_txn_mode;
  logic [2:0]             r_bit_cnt;
  logic [CNT_W-1:0]       r_byte_idx;
  logic [7:0]             r_sh_main, r_sh_sec, w_nxt_main, w_nxt_sec;

  logic                   r_byte_valid, r_mismatch, r_first_mis_valid;
  logic [7:0]             r_byte_main, r_byte_sec;
  logic [CNT_W-1:0]       r_mismatch_count, r_first_mis_byte;

  always_comb begin
    case (bus.active_mode)
      2'b10, 2'b11: bus.h_miso = bus.mf_miso;
      2'b01:        bus.h_miso = bus.sf_miso;
      default:      bus.h_miso = 1'b0;
    endcase
  end

  // Synchronizers: all four pins share the same depth so sampled MISO lines
  // stay aligned with the sampled h_clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hclk_sy <= '0;
      r_cs_sy   <= '1;
      r_mf_sy   <= '0;
      r_sf_sy   <= '0;
      r_flush   <= '0;
      r_hclk_d  <= 1'b0;
      r_cs_d    <= 1'b1;
      r_armed   <= 1'b0;
    end else begin
      r_hclk_sy <= {r_hclk_sy[SYNC_STAGES-2:0], bus.h_clk};
      r_cs_sy   <= {r_cs_sy[SYNC_STAGES-2:0], bus.h_cs_n};
      r_mf_sy   <= {r_mf_sy[SYNC_STAGES-2:0], bus.mf_miso};
      r_sf_sy   <= {r_sf_sy[SYNC_STAGES-2:0], bus.sf_miso};
      r_flush   <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_hclk_d  <= w_hclk_s;
      r_cs_d    <= w_cs_s;
      r_armed   <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs_s);
    end
  end

  assign w_hclk_s  = r_hclk_sy[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sy[SYNC_STAGES-1];
  assign w_mf_s    = r_mf_sy[SYNC_STAGES-1];
  assign w_sf_s    = r_sf_sy[SYNC_STAGES-1];
  assign w_re      = w_hclk_s & ~r_hclk_d;
  // Arming waits for a real high CS after the chain flushes its reset value,
  // so a reset inside a transaction cannot fake a CS fall.
  assign w_cs_fall = r_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise = w_cs_s & ~r_cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall || r_fall_pend) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        w_bit = w_re;
        if (w_cs_rise) w_state_nxt = CLOSE;
      end
      CLOSE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_nxt_main  = {r_sh_main[6:0], w_mf_s};
  assign w_nxt_sec   = {r_sh_sec[6:0], w_sf_s};
  assign w_byte_done = w_bit & (r_bit_cnt == 3'd7);
  assign w_cmp       = (r_txn_mode == 2'b11) && (32'(r_byte_idx) >= SKIP_L);
  assign w_mis       = w_byte_done & w_cmp & (w_nxt_main != w_nxt_sec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fall_pend       <= 1'b0;
      r_txn_mode        <= 2'b00;
      r_bit_cnt         <= 3'd0;
      r_byte_idx        <= '0;
      r_sh_main         <= 8'h00;
      r_sh_sec          <= 8'h00;
      r_byte_valid      <= 1'b0;
      r_mismatch        <= 1'b0;
      r_byte_main       <= 8'h00;
      r_byte_sec        <= 8'h00;
      r_mismatch_count  <= '0;
      r_first_mis_valid <= 1'b0;
      r_first_mis_byte  <= '0;
    end else begin
      r_fall_pend  <= (r_state == CLOSE) & w_cs_fall;
      r_byte_valid <= w_byte_done;
      r_mismatch   <= w_mis;
      if (w_start) begin
        r_txn_mode <= bus.active_mode;
        r_bit_cnt  <= 3'd0;
        r_byte_idx <= '0;
        r_sh_main  <= 8'h00;
        r_sh_sec   <= 8'h00;
      end else if (w_bit) begin
        r_sh_main <= w_nxt_main;
        r_sh_sec  <= w_nxt_sec;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_byte_done) begin
        r_byte_main <= w_nxt_main;
        r_byte_sec  <= w_nxt_sec;
        if (!(&r_byte_idx)) r_byte_idx <= r_byte_idx + CNT_ONE;
      end
      // Clear wins over a same-cycle mismatch; the pulse itself still fires.
      if (bus.clr_stats) begin
        r_mismatch_count  <= '0;
        r_first_mis_valid <= 1'b0;
        r_first_mis_byte  <= '0;
      end else if (w_mis) begin
        if (!(&r_mismatch_count)) r_mismatch_count <= r_mismatch_count + CNT_ONE;
        if (!r_first_mis_valid) begin
          r_first_mis_valid <= 1'b1;
          r_first_mis_byte  <= r_byte_idx;
        end
      end
    end
  end

  assign bus.byte_valid      = r_byte_valid;
  assign bus.mismatch        = r_mismatch;
  assign bus.byte_main       = r_byte_main;
  assign bus.byte_sec        = r_byte_sec;
  assign bus.mismatch_count  = r_mismatch_count;
  assign bus.first_mis_valid = r_first_mis_valid;
  assign bus.first_mis_byte  = r_first_mis_byte;

endmodule

// File: tb/tb_flash_miso_merge.sv
// Directed bench for flash_miso_merge: a 16-bit-counter instance and a 2-bit
// instance (for saturation) share one set of host/flash pins.
module tb_flash_miso_merge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       h_clk = 1'b0;
  logic       h_cs_n = 1'b1;
  logic       mf = 1'b0;
  logic       sf = 1'b0;
  logic [1:0] mode = 2'b11;
  logic       clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int bv_cnt   = 0;
  int mis_cnt  = 0;

  logic [7:0] txm [8];
  logic [7:0] txs [8];

  typedef struct {
    logic [1:0] mode;
    logic       mf;
    logic       sf;
    logic       exp_miso;
  } rt_t;
  rt_t rt [6];

  flash_miso_merge_if #(.CNT_W(16)) if0 ();
  flash_miso_merge_if #(.CNT_W(2))  if1 ();

  assign if0.h_clk = h_clk;       assign if1.h_clk = h_clk;
  assign if0.h_cs_n = h_cs_n;     assign if1.h_cs_n = h_cs_n;
  assign if0.mf_miso = mf;        assign if1.mf_miso = mf;
  assign if0.sf_miso = sf;        assign if1.sf_miso = sf;
  assign if0.active_mode = mode;  assign if1.active_mode = mode;
  assign if0.clr_stats = clr;     assign if1.clr_stats = clr;

  flash_miso_merge #(.SYNC_STAGES(2), .SKIP_BYTES(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  flash_miso_merge #(.SYNC_STAGES(2), .SKIP_BYTES(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if0.byte_valid) bv_cnt <= bv_cnt + 1;
    if (if0.mismatch)   mis_cnt <= mis_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] m, input logic [7:0] s, input int n);
    for (int b = 7; b > 7 - n; b--) begin
      mf = m[b];
      sf = s[b];
      #40 h_clk = 1'b1;
      #40 h_clk = 1'b0;
    end
  endtask

  task automatic txn(input int n, input int last_bits, input int chg_at, input logic [1:0] chg_mode);
    h_cs_n = 1'b0;
    #40;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) mode = chg_mode;
      spi_bits(txm[i], txs[i], (i == n - 1) ? last_bits : 8);
    end
    #40 h_cs_n = 1'b1;
    #200;
  endtask

  task automatic set_read();
    txm = '{8'h03, 8'h00, 8'h10, 8'h20, 8'hA5, 8'h3C, 8'h10, 8'h00};
    txs = txm;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    #1;
  endtask

  int bv0, mis0;

  initial begin
    rt[0] = '{2'b10, 1'b1, 1'b0, 1'b1};
    rt[1] = '{2'b01, 1'b1, 1'b0, 1'b0};
    rt[2] = '{2'b00, 1'b1, 1'b0, 1'b0};
    rt[3] = '{2'b11, 1'b1, 1'b0, 1'b1};
    rt[4] = '{2'b01, 1'b0, 1'b1, 1'b1};
    rt[5] = '{2'b10, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst byte_valid", 32'(if0.byte_valid), 0);
    chk("rst mismatch", 32'(if0.mismatch), 0);
    chk("rst byte_main", 32'(if0.byte_main), 0);
    chk("rst byte_sec", 32'(if0.byte_sec), 0);
    chk("rst count", 32'(if0.mismatch_count), 0);
    chk("rst first_valid", 32'(if0.first_mis_valid), 0);
    chk("rst first_byte", 32'(if0.first_mis_byte), 0);

    for (int i = 0; i < 6; i++) begin
      mode = rt[i].mode;
      mf = rt[i].mf;
      sf = rt[i].sf;
      #1;
      chk($sformatf("route[%0d]", i), 32'(if0.h_miso), 32'(rt[i].exp_miso));
    end
    mf = 1'b0;
    sf = 1'b0;

    // SHARE, identical data
    mode = 2'b11;
    set_read();
    bv0 = bv_cnt; mis0 = mis_cnt;
    txn(6, 8, -1, 2'b11);
    chk("match byte_valid pulses", 32'(bv_cnt - bv0), 6);
    chk("match byte_main", 32'(if0.byte_main), 32'h3C);
    chk("match byte_sec", 32'(if0.byte_sec), 32'h3C);
    chk("match mismatch pulses", 32'(mis_cnt - mis0), 0);
    chk("match count", 32'(if0.mismatch_count), 0);

    // SHARE, secondary differs at byte 5
    set_read();
    txs[5] = 8'h3D;
    mis0 = mis_cnt;
    txn(6, 8, -1, 2'b11);
    chk("mis pulses", 32'(mis_cnt - mis0), 1);
    chk("mis count", 32'(if0.mismatch_count), 1);
    chk("mis first_valid", 32'(if0.first_mis_valid), 1);
    chk("mis first_byte", 32'(if0.first_mis_byte), 5);
    chk("mis byte_sec", 32'(if0.byte_sec), 32'h3D);

    set_read();
    txs[4] = 8'hA4;
    txn(6, 8, -1, 2'b11);
    chk("mis2 count", 32'(if0.mismatch_count), 2);
    chk("mis2 first_byte kept", 32'(if0.first_mis_byte), 5);

    // difference inside the skipped header
    set_read();
    txs[2] = 8'h21;
    mis0 = mis_cnt;
    txn(6, 8, -1, 2'b11);
    chk("skip no pulse", 32'(mis_cnt - mis0), 0);
    chk("skip count", 32'(if0.mismatch_count), 2);

    // mode leaves SHARE mid-transaction; latched mode still compares
    set_read();
    txs[6] = 8'h11;
    mis0 = mis_cnt;
    txn(7, 8, 3, 2'b10);
    chk("modechg pulse", 32'(mis_cnt - mis0), 1);
    chk("modechg count", 32'(if0.mismatch_count), 3);

    set_read();
    txs[5] = 8'h3D;
    mis0 = mis_cnt;
    txn(6, 8, -1, 2'b10);
    chk("main-mode no compare", 32'(mis_cnt - mis0), 0);
    chk("main-mode count", 32'(if0.mismatch_count), 3);

    mode = 2'b11;
    pulse_clr();
    chk("clr count", 32'(if0.mismatch_count), 0);
    chk("clr first_valid", 32'(if0.first_mis_valid), 0);
    chk("clr first_byte", 32'(if0.first_mis_byte), 0);

    // partial byte 4 (5 bits), then a fresh transaction must restart at index 0
    set_read();
    txs[4] = 8'h00;
    bv0 = bv_cnt; mis0 = mis_cnt;
    txn(5, 5, -1, 2'b11);
    chk("partial byte_valid pulses", 32'(bv_cnt - bv0), 4);
    chk("partial no mismatch", 32'(mis_cnt - mis0), 0);
    chk("partial byte_main", 32'(if0.byte_main), 32'h20);
    set_read();
    txs[4] = 8'hA4;
    txn(6, 8, -1, 2'b11);
    chk("after partial first_byte", 32'(if0.first_mis_byte), 4);
    chk("after partial count", 32'(if0.mismatch_count), 1);

    // 2-bit counter saturation on u1 (compares from byte 1)
    pulse_clr();
    txm = '{8'h03, 8'h00, 8'h10, 8'h20, 8'hA5, 8'h00, 8'h00, 8'h00};
    txs = '{8'h03, 8'hFF, 8'hEF, 8'hDF, 8'h5A, 8'h00, 8'h00, 8'h00};
    txn(5, 8, -1, 2'b11);
    chk("sat u1 count", 32'(if1.mismatch_count), 3);
    chk("sat u1 first_byte", 32'(if1.first_mis_byte), 1);
    chk("sat u0 count", 32'(if0.mismatch_count), 1);

    // clear held across a mismatching byte
    set_read();
    txs[5] = 8'h3D;
    mis0 = mis_cnt;
    @(negedge clk) clr = 1'b1;
    txn(6, 8, -1, 2'b11);
    @(negedge clk) clr = 1'b0;
    #1;
    chk("clr+mis pulse", 32'(mis_cnt - mis0), 1);
    chk("clr+mis count", 32'(if0.mismatch_count), 0);
    chk("clr+mis first_valid", 32'(if0.first_mis_valid), 0);

    // make stats nonzero, then reset in the middle of a byte
    set_read();
    txs[5] = 8'h3D;
    txn(6, 8, -1, 2'b11);
    h_cs_n = 1'b0;
    #40;
    spi_bits(8'h03, 8'h03, 8);
    spi_bits(8'h00, 8'h00, 3);
    @(negedge clk) rst = 1'b1;
    #30;
    chk("midrst byte_valid", 32'(if0.byte_valid), 0);
    chk("midrst mismatch", 32'(if0.mismatch), 0);
    chk("midrst byte_main", 32'(if0.byte_main), 0);
    chk("midrst byte_sec", 32'(if0.byte_sec), 0);
    chk("midrst count", 32'(if0.mismatch_count), 0);
    chk("midrst first_valid", 32'(if0.first_mis_valid), 0);
    chk("midrst first_byte", 32'(if0.first_mis_byte), 0);
    @(negedge clk) rst = 1'b0;
    bv0 = bv_cnt;
    spi_bits(8'h00, 8'h00, 5);
    spi_bits(8'h10, 8'h10, 8);
    spi_bits(8'h20, 8'h20, 8);
    #40 h_cs_n = 1'b1;
    #200;
    chk("midrst tail ignored", 32'(bv_cnt - bv0), 0);

    set_read();
    txs[5] = 8'h3D;
    bv0 = bv_cnt;
    txn(6, 8, -1, 2'b11);
    chk("post-rst byte_valid pulses", 32'(bv_cnt - bv0), 6);
    chk("post-rst count", 32'(if0.mismatch_count), 1);
    chk("post-rst first_byte", 32'(if0.first_mis_byte), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
